// File: rtl/x_corr_lag_src_if.sv
// Load and stream buses of the correlator sample source.
interface x_corr_lag_src_if #(
    parameter int unsigned xi_bits          = 12,
    parameter int unsigned xq_bits          = 12,
    parameter int unsigned yi_bits          = 12,
    parameter int unsigned yq_bits          = 12,
    parameter int unsigned lag_counter_bits = 2
);
    // Load side
    logic signed [xi_bits-1:0]     in_xi;
    logic signed [xq_bits-1:0]     in_xq;
    logic signed [yi_bits-1:0]     in_yi;
    logic signed [yq_bits-1:0]     in_yq;
    logic                          m_axis_tvalid;
    logic                          s_axis_tready;

    // Stream side
    logic signed [xi_bits-1:0]     xi;
    logic signed [xq_bits-1:0]     xq;
    logic signed [yi_bits-1:0]     yi;
    logic signed [yq_bits-1:0]     yq;
    logic                          s_axis_tvalid;
    logic                          m_axis_tready;
    logic                          tlast;
    logic [lag_counter_bits-1:0]   lag;

    // Source (design) view
    modport master (
        input  in_xi, in_xq, in_yi, in_yq, m_axis_tvalid, m_axis_tready,
        output s_axis_tready, xi, xq, yi, yq, s_axis_tvalid, tlast, lag
    );

    // Environment view
    modport slave (
        output in_xi, in_xq, in_yi, in_yq, m_axis_tvalid, m_axis_tready,
        input  s_axis_tready, xi, xq, yi, yq, s_axis_tvalid, tlast, lag
    );
endinterface

// File: rtl/x_corr_lag_src.sv
// Correlator sample source: loads x/y buffers, then replays (x[n], y[n+k])
// for every lag k as one length-beat window per lag.
module x_corr_lag_src #(
    parameter int unsigned xi_bits             = 12,
    parameter int unsigned xq_bits             = 12,
    parameter int unsigned yi_bits             = 12,
    parameter int unsigned yq_bits             = 12,
    parameter int unsigned length              = 5,
    parameter int unsigned lags                = 4,
    parameter int unsigned length_counter_bits = 3,  // must hold length-1
    parameter int unsigned lag_counter_bits    = 2   // must hold lags-1
) (
    input  logic                    clk,
    input  logic                    reset,
    x_corr_lag_src_if.master        bus,
    output logic                    busy
);
    localparam int unsigned x_w        = xi_bits + xq_bits;
    localparam int unsigned y_w        = yi_bits + yq_bits;
    localparam int unsigned y_depth    = length + lags - 1;
    localparam int unsigned ld_bits    = (y_depth > 1) ? $clog2(y_depth) : 1;
    localparam int unsigned x_idx_bits = (length > 1) ? $clog2(length) : 1;

    localparam logic [ld_bits-1:0]             ld_last   = ld_bits'(y_depth - 1);
    localparam logic [ld_bits-1:0]             ld_x_last = ld_bits'(length - 1);
    localparam logic [length_counter_bits-1:0] n_last    = length_counter_bits'(length - 1);
    localparam logic [lag_counter_bits-1:0]    k_last    = lag_counter_bits'(lags - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t                         state_q, state_d;
    logic [ld_bits-1:0]             ld_cnt_q, ld_cnt_d;
    logic [length_counter_bits-1:0] n_q, n_d;
    logic [lag_counter_bits-1:0]    k_q, k_d;
    logic signed [xi_bits-1:0]      out_xi_q, out_xi_d;
    logic signed [xq_bits-1:0]      out_xq_q, out_xq_d;
    logic signed [yi_bits-1:0]      out_yi_q, out_yi_d;
    logic signed [yq_bits-1:0]      out_yq_q, out_yq_d;
    logic                           valid_q, valid_d;
    logic                           ready_q, ready_d;
    logic                           tlast_q, tlast_d;
    logic [lag_counter_bits-1:0]    lag_q, lag_d;
    logic                           busy_q, busy_d;

    logic [x_w-1:0] x_mem_q [length];
    logic [y_w-1:0] y_mem_q [y_depth];

    logic                           x_we, y_we;
    logic [x_idx_bits-1:0]          x_wa;
    logic [ld_bits-1:0]             y_wa;
    logic [x_w-1:0]                 x_wd, x_first;
    logic [y_w-1:0]                 y_wd, y_first;
    logic [length_counter_bits-1:0] nn;
    logic [lag_counter_bits-1:0]    nk;
    logic [ld_bits-1:0]             y_ra;
    logic                           load_fire, stream_fire;

    // Next-state, buffer write and pre-fetched output computation
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        n_d      = n_q;
        k_d      = k_q;
        out_xi_d = out_xi_q;
        out_xq_d = out_xq_q;
        out_yi_d = out_yi_q;
        out_yq_d = out_yq_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
        tlast_d  = tlast_q;
        lag_d    = lag_q;
        busy_d   = busy_q;
        x_we     = 1'b0;
        y_we     = 1'b0;
        x_wa     = x_idx_bits'(ld_cnt_q);
        y_wa     = ld_cnt_q;
        x_wd     = {bus.in_xi, bus.in_xq};
        y_wd     = {bus.in_yi, bus.in_yq};
        x_first  = x_mem_q[0];
        y_first  = y_mem_q[0];
        nn       = '0;
        nk       = '0;
        y_ra     = '0;

        load_fire   = bus.m_axis_tvalid & ready_q;
        stream_fire = valid_q & bus.m_axis_tready;

        case (state_q)
            IDLE, LOAD: begin
                if (load_fire) begin
                    y_we   = 1'b1;
                    x_we   = (ld_cnt_q <= ld_x_last);
                    busy_d = 1'b1;
                    if (ld_cnt_q == ld_last) begin
                        // Single-entry buffers: slot 0 is being written this cycle
                        if (ld_cnt_q == '0) begin
                            x_first = x_wd;
                            y_first = y_wd;
                        end
                        state_d              = STREAM;
                        ready_d              = 1'b0;
                        valid_d              = 1'b1;
                        n_d                  = '0;
                        k_d                  = '0;
                        lag_d                = '0;
                        tlast_d              = (n_last == '0);
                        {out_xi_d, out_xq_d} = x_first;
                        {out_yi_d, out_yq_d} = y_first;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                        state_d  = LOAD;
                    end
                end
            end
            STREAM: begin
                if (stream_fire) begin
                    if (n_q == n_last && k_q == k_last) begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        tlast_d  = 1'b0;
                        lag_d    = '0;
                        n_d      = '0;
                        k_d      = '0;
                        ld_cnt_d = '0;
                    end else begin
                        if (n_q == n_last) begin
                            nn = '0;
                            nk = k_q + 1'b1;
                        end else begin
                            nn = n_q + 1'b1;
                            nk = k_q;
                        end
                        n_d                  = nn;
                        k_d                  = nk;
                        lag_d                = nk;
                        tlast_d              = (nn == n_last);
                        y_ra                 = ld_bits'(nn) + ld_bits'(nk);
                        {out_xi_d, out_xq_d} = x_mem_q[x_idx_bits'(nn)];
                        {out_yi_d, out_yq_d} = y_mem_q[y_ra];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ld_cnt_q <= '0;
            n_q      <= '0;
            k_q      <= '0;
            out_xi_q <= '0;
            out_xq_q <= '0;
            out_yi_q <= '0;
            out_yq_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            tlast_q  <= 1'b0;
            lag_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            n_q      <= n_d;
            k_q      <= k_d;
            out_xi_q <= out_xi_d;
            out_xq_q <= out_xq_d;
            out_yi_q <= out_yi_d;
            out_yq_q <= out_yq_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            tlast_q  <= tlast_d;
            lag_q    <= lag_d;
            busy_q   <= busy_d;
        end
    end

    // Sample buffers; contents need no reset
    always_ff @(posedge clk) begin
        if (x_we) x_mem_q[x_wa] <= x_wd;
        if (y_we) y_mem_q[y_wa] <= y_wd;
    end

    assign bus.s_axis_tready = ready_q;
    assign bus.s_axis_tvalid = valid_q;
    assign bus.xi            = out_xi_q;
    assign bus.xq            = out_xq_q;
    assign bus.yi            = out_yi_q;
    assign bus.yq            = out_yq_q;
    assign bus.tlast         = tlast_q;
    assign bus.lag           = lag_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_x_corr_lag_src.sv
// Directed bench for x_corr_lag_src: default geometry plus a 1x1 instance.
module tb_x_corr_lag_src;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy0, busy1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic signed [11:0] ld_xi [8];
    logic signed [11:0] ld_xq [8];
    logic signed [11:0] ld_yi [8];
    logic signed [11:0] ld_yq [8];
    logic signed [11:0] ex_xi [8];
    logic signed [11:0] ex_xq [8];
    logic signed [11:0] ex_yi [8];
    logic signed [11:0] ex_yq [8];

    always #5 clk = ~clk;

    x_corr_lag_src_if #(.xi_bits(12), .xq_bits(12), .yi_bits(12), .yq_bits(12),
                        .lag_counter_bits(2)) b0 ();
    x_corr_lag_src_if #(.xi_bits(12), .xq_bits(12), .yi_bits(12), .yq_bits(12),
                        .lag_counter_bits(1)) b1 ();

    x_corr_lag_src dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.master),
        .busy  (busy0)
    );

    x_corr_lag_src #(
        .length(1), .lags(1), .length_counter_bits(1), .lag_counter_bits(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.master),
        .busy  (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int x0, input int xs, input int y0, input int ys, input int qsign);
        for (int j = 0; j < 8; j++) begin
            ld_xi[j] = 12'(x0 + xs * j);
            ld_xq[j] = 12'(qsign * (x0 + xs * j));
            ld_yi[j] = 12'(y0 + ys * j);
            ld_yq[j] = 12'(qsign * (y0 + ys * j));
        end
    endtask

    task automatic drive_beat0(input int i);
        b0.in_xi = (i < 5) ? ld_xi[i] : 12'sh5A5;
        b0.in_xq = (i < 5) ? ld_xq[i] : 12'sh35A;
        b0.in_yi = ld_yi[i];
        b0.in_yq = ld_yq[i];
    endtask

    task automatic load0(input bit gap);
        int i = 0;
        int guard = 0;
        bit fire;
        while (i < 8 && guard < 200) begin
            drive_beat0(i);
            b0.m_axis_tvalid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            check("ld_tready", 32'(b0.s_axis_tready), 32'd1);
            check("ld_tvalid", 32'(b0.s_axis_tvalid), 32'd0);
            fire = b0.m_axis_tvalid & b0.s_axis_tready;
            step();
            guard++;
            if (fire) i++;
        end
        b0.m_axis_tvalid = 1'b0;
        check("ld_done", 32'(i), 32'd8);
        for (int j = 0; j < 8; j++) begin
            ex_xi[j] = ld_xi[j];
            ex_xq[j] = ld_xq[j];
            ex_yi[j] = ld_yi[j];
            ex_yq[j] = ld_yq[j];
        end
        check("first_tvalid", 32'(b0.s_axis_tvalid), 32'd1);
        check("first_tready", 32'(b0.s_axis_tready), 32'd0);
        check("first_busy", 32'(busy0), 32'd1);
    endtask

    task automatic stream0(input int pat, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int n, k;
        bit stalled = 1'b0;
        bit rdy;
        logic [31:0] h_xi, h_xq, h_yi, h_yq, h_tl, h_lag;
        while (idx < stop_after && cyc < 500) begin
            if (stalled) begin
                check("stall_tvalid", 32'(b0.s_axis_tvalid), 32'd1);
                check("stall_xi", 32'(b0.xi), h_xi);
                check("stall_xq", 32'(b0.xq), h_xq);
                check("stall_yi", 32'(b0.yi), h_yi);
                check("stall_yq", 32'(b0.yq), h_yq);
                check("stall_tlast", 32'(b0.tlast), h_tl);
                check("stall_lag", 32'(b0.lag), h_lag);
            end
            rdy = (pat == 0) || (cyc % 3 == 0);
            b0.m_axis_tready = rdy;
            check("str_tready", 32'(b0.s_axis_tready), 32'd0);
            if (b0.s_axis_tvalid) begin
                if (rdy) begin
                    n = idx % 5;
                    k = idx / 5;
                    check("beat_xi", 32'(b0.xi), 32'(ex_xi[n]));
                    check("beat_xq", 32'(b0.xq), 32'(ex_xq[n]));
                    check("beat_yi", 32'(b0.yi), 32'(ex_yi[n + k]));
                    check("beat_yq", 32'(b0.yq), 32'(ex_yq[n + k]));
                    check("beat_tlast", 32'(b0.tlast), 32'(n == 4));
                    check("beat_lag", 32'(b0.lag), 32'(k));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    h_xi  = 32'(b0.xi);
                    h_xq  = 32'(b0.xq);
                    h_yi  = 32'(b0.yi);
                    h_yq  = 32'(b0.yq);
                    h_tl  = 32'(b0.tlast);
                    h_lag = 32'(b0.lag);
                    stalled = 1'b1;
                end
            end else begin
                check("tvalid_drop", 32'(b0.s_axis_tvalid), 32'd1);
            end
            step();
            cyc++;
        end
        b0.m_axis_tready = 1'b0;
        check("str_beats", 32'(idx), 32'(stop_after));
        if (pat == 0) check("str_cycles", 32'(cyc), 32'(stop_after));
    endtask

    task automatic post_idle0();
        check("end_tvalid", 32'(b0.s_axis_tvalid), 32'd0);
        check("end_tready", 32'(b0.s_axis_tready), 32'd1);
        check("end_busy", 32'(busy0), 32'd0);
    endtask

    initial begin
        b0.in_xi = '0; b0.in_xq = '0; b0.in_yi = '0; b0.in_yq = '0;
        b0.m_axis_tvalid = 1'b0; b0.m_axis_tready = 1'b0;
        b1.in_xi = '0; b1.in_xq = '0; b1.in_yi = '0; b1.in_yq = '0;
        b1.m_axis_tvalid = 1'b0; b1.m_axis_tready = 1'b0;

        // Reset values
        reset = 1'b1;
        step();
        step();
        check("rst_tvalid", 32'(b0.s_axis_tvalid), 32'd0);
        check("rst_tready", 32'(b0.s_axis_tready), 32'd1);
        check("rst_tlast", 32'(b0.tlast), 32'd0);
        check("rst_lag", 32'(b0.lag), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_data", {b0.xi[7:0], b0.xq[7:0], b0.yi[7:0], b0.yq[7:0]}, 32'd0);
        check("rst1_tvalid", 32'(b1.s_axis_tvalid), 32'd0);
        check("rst1_tready", 32'(b1.s_axis_tready), 32'd1);
        reset = 1'b0;
        step();

        // Default load and full-rate stream
        set_data(1, 1, 10, 1, 1);
        load0(1'b0);
        check("lag0_first_yi", 32'(b0.yi), 32'd10);
        stream0(0, 20);
        post_idle0();

        // Backpressure 1-of-3
        load0(1'b0);
        stream0(1, 20);
        post_idle0();

        // Gappy load
        set_data(21, 2, 30, 3, -1);
        load0(1'b1);
        stream0(0, 20);
        post_idle0();

        // Load held pending across a stream, then back-to-back load
        set_data(3, 5, -7, 4, 1);
        load0(1'b0);
        set_data(100, -9, 200, -11, -1);
        drive_beat0(0);
        b0.m_axis_tvalid = 1'b1;
        stream0(0, 20);
        post_idle0();
        load0(1'b0);
        stream0(0, 20);
        post_idle0();

        // Reset after seven beats
        set_data(50, 1, 60, 1, 1);
        load0(1'b0);
        stream0(0, 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_tvalid", 32'(b0.s_axis_tvalid), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_tready", 32'(b0.s_axis_tready), 32'd1);
        check("abort_lag", 32'(b0.lag), 32'd0);
        set_data(70, 2, 80, 2, -1);
        load0(1'b0);
        check("reload_xi", 32'(b0.xi), 32'd70);
        check("reload_yi", 32'(b0.yi), 32'd80);
        stream0(0, 20);
        post_idle0();

        // Signed extremes
        for (int j = 0; j < 8; j++) begin
            ld_xi[j] = (j % 2 == 0) ? -12'sd2048 : 12'sd2047;
            ld_xq[j] = (j % 2 == 0) ? 12'sd2047 : -12'sd2048;
            ld_yi[j] = -12'sd2048;
            ld_yq[j] = -12'sd2048;
        end
        load0(1'b0);
        check("ext_xi", 32'(b0.xi), 32'hFFFF_F800);
        check("ext_xq", 32'(b0.xq), 32'h0000_07FF);
        stream0(0, 20);
        post_idle0();

        // 1x1 geometry: single beat window
        b1.in_xi = -12'sd2048;
        b1.in_xq = 12'sd2047;
        b1.in_yi = -12'sd2048;
        b1.in_yq = 12'sd2047;
        b1.m_axis_tvalid = 1'b1;
        check("one_ld_tready", 32'(b1.s_axis_tready), 32'd1);
        step();
        b1.m_axis_tvalid = 1'b0;
        check("one_tvalid", 32'(b1.s_axis_tvalid), 32'd1);
        check("one_tready", 32'(b1.s_axis_tready), 32'd0);
        check("one_busy", 32'(busy1), 32'd1);
        step();
        check("one_hold_tvalid", 32'(b1.s_axis_tvalid), 32'd1);
        check("one_tlast", 32'(b1.tlast), 32'd1);
        check("one_lag", 32'(b1.lag), 32'd0);
        check("one_xi", 32'(b1.xi), 32'hFFFF_F800);
        check("one_xq", 32'(b1.xq), 32'h0000_07FF);
        check("one_yi", 32'(b1.yi), 32'hFFFF_F800);
        check("one_yq", 32'(b1.yq), 32'h0000_07FF);
        b1.m_axis_tready = 1'b1;
        step();
        b1.m_axis_tready = 1'b0;
        check("one_end_tvalid", 32'(b1.s_axis_tvalid), 32'd0);
        check("one_end_tready", 32'(b1.s_axis_tready), 32'd1);
        check("one_end_busy", 32'(busy1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
